// File: rtl/sine_pkg.sv
// rtl/sine_pkg.sv - shared widths and FSM state encoding for the sine sequencer
package sine_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - divides clk down to a one-cycle sample tick
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!enable || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = enable && (cnt_q == LAST);
endmodule

// File: rtl/sine_sequencer.sv
// rtl/sine_sequencer.sv - phase accumulator driving a fixed-latency sine memory
// and presenting captured samples on a valid/ready handshake
module sine_sequencer
  import sine_pkg::*;
#(
  parameter int SAMPLE_DIV = 1000,
  parameter int PHASE_W    = 16,
  parameter int MEM_LAT    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] tuning_word,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_data,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  output logic [7:0]         overrun_count,
  output logic               busy
);
  localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  generate
    if (SAMPLE_DIV < MEM_LAT + 3 || MEM_LAT < 1) begin : g_bad_cfg
      $error("sine_sequencer: SAMPLE_DIV must be at least MEM_LAT+3 and MEM_LAT at least 1");
    end
  endgenerate

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   sample_d;
  logic                valid_d;
  logic                overrun_d;
  logic [7:0]          count_d;
  logic                tick;
  logic                lost;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      wait_q        <= '0;
      mem_addr      <= '0;
      sample        <= '0;
      sample_valid  <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      wait_q        <= wait_d;
      mem_addr      <= addr_d;
      sample        <= sample_d;
      sample_valid  <= valid_d;
      overrun       <= overrun_d;
      overrun_count <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    addr_d    = mem_addr;
    sample_d  = sample;
    valid_d   = sample_valid;
    overrun_d = 1'b0;
    count_d   = overrun_count;
    lost      = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      if (sample_valid && sample_ready) valid_d = 1'b0;

      case (state_q)
        IDLE: begin
          if (tick) begin
            addr_d  = phase_q[PHASE_W-1 -: ADDR_W];
            phase_d = phase_q + tuning_word;
            wait_d  = WAIT_W'(MEM_LAT - 1);
            state_d = WAIT;
          end
        end
        WAIT: begin
          lost   = tick;
          wait_d = wait_q - 1'b1;
          if (wait_q == '0) state_d = CAPTURE;
        end
        CAPTURE: begin
          // A capture and a consumer pop on the same edge keeps valid high with fresh data.
          if (!sample_valid || sample_ready) begin
            sample_d = mem_data;
            valid_d  = 1'b1;
          end else begin
            lost = 1'b1;
          end
          if (tick) lost = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (lost) begin
        overrun_d = 1'b1;
        if (overrun_count != 8'hFF) count_d = overrun_count + 8'd1;
      end
    end
  end

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_sine_sequencer.sv
// tb/tb_sine_sequencer.sv - directed self-checking bench for sine_sequencer
module tb_sine_sequencer;
  localparam int SAMPLE_DIV = 8;
  localparam int MEM_LAT    = 3;
  localparam int PHASE_W    = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               enable = 1'b0;
  logic [PHASE_W-1:0] tuning_word = '0;
  logic [8:0]         mem_addr;
  logic [9:0]         mem_data;
  logic [9:0]         sample;
  logic               sample_valid;
  logic               sample_ready = 1'b1;
  logic               overrun;
  logic [7:0]         overrun_count;
  logic               busy;

  logic [8:0] m1, m2;
  logic [9:0] m3;

  int checks = 0;
  int errors = 0;

  sine_sequencer #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .PHASE_W    (PHASE_W),
    .MEM_LAT    (MEM_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .tuning_word   (tuning_word),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun),
    .overrun_count (overrun_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Three-cycle memory returning {1'b0, addr}.
  always @(posedge clk) begin
    m1 <= mem_addr;
    m2 <= m1;
    m3 <= {1'b0, m2};
  end
  assign mem_data = m3;

  task automatic apply_reset(input logic [PHASE_W-1:0] tw, input logic rdy);
    @(negedge clk);
    enable       = 1'b0;
    rst_n        = 1'b0;
    tuning_word  = tw;
    sample_ready = rdy;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  // Returns at the first negedge where busy is high; a timeout is a failed check.
  task automatic wait_issue(input string name, output int cycles);
    bit ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 4 * SAMPLE_DIV; i++) begin
      @(negedge clk);
      cycles++;
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no issue within %0d cycles (busy=%0b, required 1)", name, cycles, busy);
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks += 6;
    if (mem_addr !== 9'd0)      begin errors++; $display("FAIL reset_mem_addr: got %0d required 0", mem_addr); end
    if (sample !== 10'd0)       begin errors++; $display("FAIL reset_sample: got %0d required 0", sample); end
    if (sample_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %0b required 0", sample_valid); end
    if (overrun !== 1'b0)       begin errors++; $display("FAIL reset_overrun: got %0b required 0", overrun); end
    if (overrun_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", overrun_count); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
  endtask

  task automatic test_basic();
    int cyc;
    bit ov_seen = 1'b0;
    apply_reset(16'h0080, 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_issue("basic_issue", cyc);
      checks++;
      if (mem_addr !== 9'(k)) begin errors++; $display("FAIL basic_addr[%0d]: got %0d required %0d", k, mem_addr, k); end
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (overrun) ov_seen = 1'b1;
        if (c == 3) begin
          checks++;
          if (sample_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early[%0d]: got %0b required 0", k, sample_valid); end
        end
      end
      checks += 2;
      if (sample_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %0b required 1", k, sample_valid); end
      if (sample !== 10'(k))     begin errors++; $display("FAIL basic_sample[%0d]: got %0d required %0d", k, sample, k); end
    end
    checks += 2;
    if (ov_seen !== 1'b0)       begin errors++; $display("FAIL basic_overrun: got %0b required 0", ov_seen); end
    if (overrun_count !== 8'd0) begin errors++; $display("FAIL basic_count: got %0d required 0", overrun_count); end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [8:0] exp_addr [4] = '{9'd0, 9'd256, 9'd0, 9'd256};
    apply_reset(16'h8000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_issue("wrap_issue", cyc);
      checks++;
      if (mem_addr !== exp_addr[k]) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", k, mem_addr, exp_addr[k]); end
      repeat (4) @(negedge clk);
      checks++;
      if (sample !== {1'b0, exp_addr[k]}) begin errors++; $display("FAIL wrap_sample[%0d]: got %0d required %0d", k, sample, exp_addr[k]); end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int pulses = 0;
    apply_reset(16'h0080, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_issue("bp_issue", cyc);
      repeat (4) begin
        @(negedge clk);
        if (overrun) pulses++;
      end
    end
    checks += 4;
    if (sample !== 10'd0)       begin errors++; $display("FAIL bp_sample_held: got %0d required 0", sample); end
    if (sample_valid !== 1'b1)  begin errors++; $display("FAIL bp_valid_held: got %0b required 1", sample_valid); end
    if (pulses != 2)            begin errors++; $display("FAIL bp_pulses: got %0d required 2", pulses); end
    if (overrun_count !== 8'd2) begin errors++; $display("FAIL bp_count: got %0d required 2", overrun_count); end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    checks++;
    if (sample_valid !== 1'b0)  begin errors++; $display("FAIL bp_drain: got %0b required 0", sample_valid); end
  endtask

  task automatic test_capture_handshake();
    int cyc;
    apply_reset(16'h0080, 1'b0);
    wait_issue("hs_issue0", cyc);
    repeat (4) @(negedge clk);
    wait_issue("hs_issue1", cyc);
    repeat (3) @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    checks += 4;
    if (sample_valid !== 1'b1)  begin errors++; $display("FAIL hs_valid: got %0b required 1", sample_valid); end
    if (sample !== 10'd1)       begin errors++; $display("FAIL hs_sample: got %0d required 1", sample); end
    if (overrun !== 1'b0)       begin errors++; $display("FAIL hs_overrun: got %0b required 0", overrun); end
    if (overrun_count !== 8'd0) begin errors++; $display("FAIL hs_count: got %0d required 0", overrun_count); end
    sample_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    apply_reset(16'h0080, 1'b1);
    wait_issue("mid_issue0", cyc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (mem_addr !== 9'd0)      begin errors++; $display("FAIL mid_mem_addr: got %0d required 0", mem_addr); end
    if (sample !== 10'd0)       begin errors++; $display("FAIL mid_sample: got %0d required 0", sample); end
    if (sample_valid !== 1'b0)  begin errors++; $display("FAIL mid_valid: got %0b required 0", sample_valid); end
    if (overrun !== 1'b0)       begin errors++; $display("FAIL mid_overrun: got %0b required 0", overrun); end
    if (overrun_count !== 8'd0) begin errors++; $display("FAIL mid_count: got %0d required 0", overrun_count); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL mid_busy: got %0b required 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_issue("mid_issue1", cyc);
    checks += 2;
    if (cyc != SAMPLE_DIV)  begin errors++; $display("FAIL mid_tick_delay: got %0d required %0d", cyc, SAMPLE_DIV); end
    if (mem_addr !== 9'd0)  begin errors++; $display("FAIL mid_first_addr: got %0d required 0", mem_addr); end
    repeat (4) @(negedge clk);
    checks += 2;
    if (sample !== 10'd0 || sample_valid !== 1'b1) begin errors++; $display("FAIL mid_sample_after: got %0d/%0b required 0/1", sample, sample_valid); end
    if (overrun_count !== 8'd0) begin errors++; $display("FAIL mid_count_after: got %0d required 0", overrun_count); end
  endtask

  task automatic test_saturate();
    int cyc;
    int pulses = 0;
    apply_reset(16'h0080, 1'b0);
    for (int k = 0; k < 301; k++) begin
      wait_issue("sat_issue", cyc);
      repeat (4) begin
        @(negedge clk);
        if (overrun) pulses++;
      end
    end
    checks += 2;
    if (pulses != 300)            begin errors++; $display("FAIL sat_pulses: got %0d required 300", pulses); end
    if (overrun_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d required 255", overrun_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_capture_handshake();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sine_sequencer.md
SINE_SEQUENCER -- requirements
Module: sine_sequencer

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 1000, giving clk cycles per sample tick.
REQ-002 The block SHALL have parameter PHASE_W, default 16, giving the phase accumulator width.
REQ-003 The block SHALL have parameter MEM_LAT, default 3, giving cycles from a stable mem_addr to a valid mem_data.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port enable, input, 1 bit, which runs tick generation and sequencing while high.
REQ-007 The block SHALL have port tuning_word, input, PHASE_W bits, the phase increment per sample.
REQ-008 The block SHALL have port mem_addr, output, 9 bits, the read address to the sine sample memory.
REQ-009 The block SHALL have port mem_data, input, 10 bits, the read data from the sine sample memory.
REQ-010 The block SHALL have port sample, output, 10 bits, the captured sample.
REQ-011 The block SHALL have ports sample_valid, output, 1 bit, and sample_ready, input, 1 bit, forming a valid/ready handshake.
REQ-012 The block SHALL have port overrun, output, 1 bit, a one-cycle pulse flagging a lost sample.
REQ-013 The block SHALL have port overrun_count, output, 8 bits, a saturating count of lost samples.
REQ-014 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-015 The tick counter SHALL count 0..SAMPLE_DIV-1 while enable=1, asserting tick for one cycle when the count equals SAMPLE_DIV-1, then wrap to 0.
REQ-016 While enable=0, the tick counter SHALL be held at 0, the FSM SHALL go to IDLE at the next edge, and phase, sample and sample_valid SHALL hold.
REQ-017 The FSM SHALL have states IDLE, WAIT and CAPTURE.
REQ-018 IDLE: on tick, the FSM SHALL load mem_addr with phase[PHASE_W-1:PHASE_W-9], set phase to phase+tuning_word mod 2^PHASE_W, load the wait counter with MEM_LAT-1, and go to WAIT.
REQ-019 WAIT: the FSM SHALL decrement the wait counter each cycle and go to CAPTURE after the cycle in which it reads 0, giving MEM_LAT cycles in WAIT.
REQ-020 mem_addr SHALL be held stable from issue through CAPTURE, because the memory's quadrant mirroring pipeline requires a stable address.
REQ-021 CAPTURE, when sample_valid=0 or sample_ready=1: sample SHALL be loaded with mem_data, sample_valid set to 1, and the FSM return to IDLE.
REQ-022 CAPTURE, when sample_valid=1 and sample_ready=0: mem_data SHALL be discarded, sample held, overrun pulsed, overrun_count incremented (saturating at 255), and the FSM return to IDLE.
REQ-023 sample_valid SHALL clear on an edge with sample_valid=1 and sample_ready=1, unless a capture occurs on the same edge, in which case it stays 1 with the new data.
REQ-024 A tick arriving while the FSM is not IDLE SHALL be dropped, pulsing overrun and incrementing overrun_count.
REQ-025 SAMPLE_DIV SHALL be at least MEM_LAT+3; smaller values are a configuration error flagged by an elaboration-time assertion.
REQ-026 tuning_word SHALL be sampled only in IDLE on tick, so mid-sequence changes take effect on the next sample.

Reset
REQ-027 On rst_n=0 the block SHALL asynchronously set: FSM to IDLE, tick counter, phase, wait counter, mem_addr, sample, sample_valid, overrun, overrun_count and busy all to 0.
REQ-028 When rst_n asserts mid-sequence, the in-flight sample SHALL be lost without an overrun, and the first tick after release SHALL come SAMPLE_DIV cycles after the first enabled edge.

Structure
REQ-029 Package sine_pkg SHALL hold ADDR_W=9, DATA_W=10 and the FSM state enum (IDLE, WAIT, CAPTURE).
REQ-030 The tick divider SHALL be a sub-module named sample_tick_gen, with ports clk, rst_n, enable and tick.

Verification
The bench SHALL use SAMPLE_DIV=8, MEM_LAT=3, and a memory model with 3-cycle latency returning {1'b0, addr}.
REQ-031 Stimulus: tuning_word=0x0080, sample_ready=1, enable high for 5 ticks. Required response: mem_addr sequence 0,1,2,3,4; sample sequence 0,1,2,3,4; each sample_valid high 4 cycles after its issue; no overrun.
REQ-032 Stimulus: tuning_word=0x8000. Required response: mem_addr alternates 0,256,0,256; phase wraps to 0x0000 after every 2 samples.
REQ-033 Stimulus: sample_ready=0 for 3 ticks. Required response: first sample held; 2 overrun pulses; overrun_count=2; after sample_ready=1 for one cycle, sample_valid=0.
REQ-034 Stimulus: sample_ready=1 on the exact capture edge of a new sample. Required response: sample_valid stays 1 and sample updates to the new value.
REQ-035 Stimulus: rst_n pulsed low during WAIT. Required response: all outputs read 0 immediately; first mem_addr after release is 0; overrun stays 0.
REQ-036 Stimulus: 300 forced overruns. Required response: overrun_count saturates at 255.
